counter_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the loadable up/down counter and drives its `load`, `mode` and `din` inputs. It accepts LOAD, UP, DOWN and HOLD commands over a valid/ready handshake and expands each one into cycle-by-cycle counter controls. The counter has no enable, so the sequencer holds it by reloading its own value. To do this, it keeps a shadow copy that equals the counter output every cycle.

---
 rtl/counter_cmd_seq.sv | 189 ++++++++++++++++++
 tb/tb_counter_cmd_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_seq.sv
// counter_cmd_seq: command sequencer in front of a 4-bit loadable up/down counter.
// Expands LOAD / UP / DOWN / HOLD commands into per-cycle load/mode/din controls
// and keeps a shadow copy that tracks the counter output every cycle.
// Optional feature macro: SEQ_SAT_EN (saturating UP/DOWN with a sat pulse).
// Without SEQ_SAT_EN the counter wraps modulo 16 and sat stays 0.
module counter_cmd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_arg,
  output logic       load,
  output logic       mode,
  output logic [3:0] din,
  output logic [3:0] shadow,
  output logic       done,
  output logic       sat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

`ifdef SEQ_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  // Control bundle; registered so no command input reaches an output combinationally.
  typedef struct packed {
    logic       ready;
    logic       load;
    logic       mode;
    logic [3:0] din;
    logic       done;
    logic       sat;
  } ctl_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] arg_q, arg_d;
  logic [3:0] rem_q, rem_d;
  logic [3:0] shadow_q, shadow_d;
  ctl_t       ctl_q, ctl_d;

  // A step that would cross the 0/F boundary while saturation is enabled.
  function automatic logic step_blocked(input logic [1:0] op, input logic [3:0] sh);
    logic hit;
    case (op)
      OP_UP:   hit = (sh == 4'hF);
      OP_DOWN: hit = (sh == 4'h0);
      default: hit = 1'b0;
    endcase
    return hit & SAT_EN;
  endfunction

  // Counter value after one RUN step; blocked steps and HOLD leave it unchanged.
  function automatic logic [3:0] step_value(input logic [1:0] op, input logic [3:0] sh);
    logic [3:0] nv;
    case (op)
      OP_UP:   nv = step_blocked(op, sh) ? sh : sh + 4'd1;
      OP_DOWN: nv = step_blocked(op, sh) ? sh : sh - 4'd1;
      default: nv = sh;
    endcase
    return nv;
  endfunction

  // Controls implied by a given (state, command, rem, shadow) snapshot.
  // Default is the hold pattern: reload the counter with its own value.
  function automatic ctl_t decode(input state_t st, input logic [1:0] op,
                                  input logic [3:0] arg, input logic [3:0] rem,
                                  input logic [3:0] sh);
    ctl_t c;
    c.ready = 1'b0;
    c.load  = 1'b1;
    c.mode  = 1'b0;
    c.din   = sh;
    c.done  = 1'b0;
    c.sat   = 1'b0;
    case (st)
      ST_IDLE: begin
        c.ready = 1'b1;
      end
      ST_LOAD: begin
        c.din  = arg;
        c.done = 1'b1;
      end
      ST_RUN: begin
        c.done = (rem == 4'd0);
        case (op)
          OP_UP, OP_DOWN: begin
            if (step_blocked(op, sh)) begin
              c.sat = 1'b1;
            end else begin
              c.load = 1'b0;
              c.mode = (op == OP_UP);
            end
          end
          default: begin
            c.load = 1'b1;
          end
        endcase
      end
      default: begin
        c.ready = 1'b0;
      end
    endcase
    return c;
  endfunction

  // Next-state, command latch, step counter and shadow update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    arg_d    = arg_q;
    rem_d    = rem_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          arg_d   = cmd_arg;
          rem_d   = cmd_arg;
          state_d = (cmd_op == OP_LOAD) ? ST_LOAD : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        shadow_d = arg_q;
        state_d  = ST_IDLE;
      end
      ST_RUN: begin
        shadow_d = step_value(op_q, shadow_q);
        if (rem_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          rem_d = rem_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ctl_d = decode(state_d, op_d, arg_d, rem_d, shadow_d);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_HOLD;
      arg_q       <= 4'd0;
      rem_q       <= 4'd0;
      shadow_q    <= 4'd0;
      ctl_q.ready <= 1'b1;
      ctl_q.load  <= 1'b1;
      ctl_q.mode  <= 1'b0;
      ctl_q.din   <= 4'd0;
      ctl_q.done  <= 1'b0;
      ctl_q.sat   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      arg_q    <= arg_d;
      rem_q    <= rem_d;
      shadow_q <= shadow_d;
      ctl_q    <= ctl_d;
    end
  end

  assign cmd_ready = ctl_q.ready;
  assign load      = ctl_q.load;
  assign mode      = ctl_q.mode;
  assign din       = ctl_q.din;
  assign done      = ctl_q.done;
  assign sat       = ctl_q.sat;
  assign shadow    = shadow_q;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq: behavioural command model (per-cycle expectation
// queue) plus a behavioural counter driven by the DUT controls.
module tb_counter_cmd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       load;
  logic       mode;
  logic [3:0] din;
  logic [3:0] shadow;
  logic       done;
  logic       sat;

  always #5 clk = ~clk;

  counter_cmd_seq dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .load(load), .mode(mode), .din(din),
    .shadow(shadow), .done(done), .sat(sat)
  );

`ifdef SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // behavioural counter fed by the sequencer controls
  logic [3:0] cnt;
  always @(posedge clk) begin
    if (!rst) cnt <= 4'd0;
    else if (load) cnt <= din;
    else if (mode) cnt <= cnt + 4'd1;
    else cnt <= cnt - 4'd1;
  end

  typedef struct {
    logic       ready;
    logic       load;
    logic       mode;
    logic       mode_chk;
    logic [3:0] din;
    logic       din_chk;
    logic       done;
    logic       sat;
    logic [3:0] shadow;
    logic [3:0] nxt;
  } exp_t;

  exp_t       exq[$];
  int         n_checks = 0;
  int         n_err = 0;
  logic [3:0] m_sh = 4'd0;
  bit         m_idle = 1'b1;
  bit         chk_en = 1'b0;
  int         done_seen = 0;
  int         sat_seen = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic l, input logic m, input logic mc,
                              input logic [3:0] d, input logic dc, input logic dn,
                              input logic st, input logic [3:0] sh, input logic [3:0] nx);
    exp_t e;
    e.ready = 1'b0; e.load = l; e.mode = m; e.mode_chk = mc; e.din = d;
    e.din_chk = dc; e.done = dn; e.sat = st; e.shadow = sh; e.nxt = nx;
    return e;
  endfunction

  // expected per-cycle behaviour of one accepted command, starting from m_sh
  task automatic push_cmd(input logic [1:0] op, input logic [3:0] arg);
    logic [3:0] s;
    exp_t e;
    logic dn;
    s = m_sh;
    if (op == 2'b00) begin
      exq.push_back(mk(1'b1, 1'b0, 1'b0, arg, 1'b1, 1'b1, 1'b0, s, arg));
    end else begin
      for (int k = 0; k <= int'(arg); k++) begin
        dn = (k == int'(arg));
        if (op == 2'b01) begin
          if (SAT && s == 4'hF) e = mk(1'b1, 1'b0, 1'b0, 4'hF, 1'b1, dn, 1'b1, s, s);
          else e = mk(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, dn, 1'b0, s, s + 4'd1);
        end else if (op == 2'b10) begin
          if (SAT && s == 4'h0) e = mk(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, dn, 1'b1, s, s);
          else e = mk(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, dn, 1'b0, s, s - 4'd1);
        end else begin
          e = mk(1'b1, 1'b0, 1'b1, s, 1'b1, dn, 1'b0, s, s);
        end
        exq.push_back(e);
        s = e.nxt;
      end
    end
  endtask

  // single compare process: every cycle, DUT outputs vs model expectation
  exp_t ce;
  always @(negedge clk) begin
    if (chk_en) begin
      if (exq.size() > 0) begin
        ce = exq.pop_front();
        m_idle = 1'b0;
      end else begin
        ce = mk(1'b1, 1'b0, 1'b1, m_sh, 1'b1, 1'b0, 1'b0, m_sh, m_sh);
        ce.ready = 1'b1;
        m_idle = 1'b1;
      end
      chk("cmd_ready", 8'(cmd_ready), 8'(ce.ready));
      chk("load", 8'(load), 8'(ce.load));
      chk("done", 8'(done), 8'(ce.done));
      chk("sat", 8'(sat), 8'(ce.sat));
      chk("shadow", 8'(shadow), 8'(ce.shadow));
      chk("shadow_vs_counter", 8'(shadow), 8'(cnt));
      if (ce.din_chk) chk("din", 8'(din), 8'(ce.din));
      if (ce.mode_chk) chk("mode", 8'(mode), 8'(ce.mode));
      if (done === 1'b1) done_seen++;
      if (sat === 1'b1) sat_seen++;
      m_sh = ce.nxt;
    end
  end

  // present a command and hold it until the model says it was accepted
  task automatic send(input logic [1:0] op, input logic [3:0] arg);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    while (!ok && t < 64) begin
      @(posedge clk); #2;
      t++;
      if (m_idle) ok = 1'b1;
    end
    if (ok) push_cmd(op, arg);
    else chk("send_timeout", 8'd1, 8'd0);
    cmd_valid = 1'b0; cmd_op = 2'b01; cmd_arg = ~arg;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(m_idle && exq.size() == 0) && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 100) chk("idle_timeout", 8'd1, 8'd0);
  endtask

  int d0;
  int s0;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1; m_sh = 4'd0; chk_en = 1'b1;
    repeat (4) begin @(posedge clk); #2; end
    chk("reset_shadow", 8'(shadow), 8'h0);
    chk("reset_din", 8'(din), 8'h0);

    // LOAD 3: controls in cycle after acceptance, shadow=3 after, ready again
    send(2'b00, 4'd3);
    chk("load3_load", 8'(load), 8'h1);
    chk("load3_din", 8'(din), 8'h3);
    chk("load3_done", 8'(done), 8'h1);
    @(posedge clk); #2;
    chk("load3_shadow", 8'(shadow), 8'h3);
    chk("load3_ready", 8'(cmd_ready), 8'h1);
    wait_idle();

    // UP arg 4 from 3 -> 8, one done
    d0 = done_seen;
    send(2'b01, 4'd4);
    wait_idle();
    chk("up4_shadow", 8'(shadow), 8'h8);
    chk("up4_dones", 8'(done_seen - d0), 8'd1);

    // DOWN arg 2 from 1 -> wrap or saturate
    send(2'b00, 4'd1);
    wait_idle();
    s0 = sat_seen;
    send(2'b10, 4'd2);
    wait_idle();
    chk("down_shadow", 8'(shadow), SAT ? 8'h0 : 8'hE);
    chk("down_sats", 8'(sat_seen - s0), SAT ? 8'd2 : 8'd0);

    // UP across F
    send(2'b00, 4'd14);
    wait_idle();
    s0 = sat_seen;
    send(2'b01, 4'd2);
    wait_idle();
    chk("upwrap_shadow", 8'(shadow), SAT ? 8'hF : 8'h1);
    chk("upwrap_sats", 8'(sat_seen - s0), SAT ? 8'd2 : 8'd0);

    // longest command: UP arg 15 from 0
    send(2'b00, 4'd0);
    wait_idle();
    s0 = sat_seen;
    send(2'b01, 4'd15);
    wait_idle();
    chk("up16_shadow", 8'(shadow), SAT ? 8'hF : 8'h0);
    chk("up16_sats", 8'(sat_seen - s0), SAT ? 8'd1 : 8'd0);

    // HOLD arg 2 at 7, with LOAD 5 presented while busy
    send(2'b00, 4'd7);
    wait_idle();
    d0 = done_seen;
    send(2'b11, 4'd2);
    send(2'b00, 4'd5);
    wait_idle();
    chk("busy_shadow", 8'(shadow), 8'h5);
    chk("busy_dones", 8'(done_seen - d0), 8'd2);

    // reset during the 3rd step of UP arg 9
    send(2'b01, 4'd9);
    d0 = done_seen;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    exq.delete();
    m_sh = 4'd0;
    rst = 1'b1;
    chk("rst_mid_shadow", 8'(shadow), 8'h0);
    chk("rst_mid_cnt", 8'(cnt), 8'h0);
    chk("rst_mid_ready", 8'(cmd_ready), 8'h1);
    repeat (3) begin @(posedge clk); #2; end
    chk("rst_mid_dones", 8'(done_seen - d0), 8'd0);

    send(2'b00, 4'd9);
    wait_idle();
    chk("post_rst_load", 8'(shadow), 8'h9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
